rv32_multicycle_control: RTL and testbench



---
 rtl/rv32_pkg.sv | 116 +++++++++++
 rtl/rv32_instr_decoder.sv | 99 +++++++++
 rtl/rv32_multicycle_control.sv | 225 ++++++++++++++++++++++
 tb/tb_rv32_multicycle_control.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared types for the RV32I multicycle core: ALU op codes, opcodes,
// control-FSM states, datapath select encodings and small decode helpers.
package rv32_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SRL  = 5'd3,
        ALU_SRA  = 5'd4,
        ALU_SLT  = 5'd5,
        ALU_SLTU = 5'd6,
        ALU_XOR  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_BEQ  = 5'd10,
        ALU_BNE  = 5'd11,
        ALU_BLT  = 5'd12,
        ALU_BGE  = 5'd13,
        ALU_BLTU = 5'd14,
        ALU_BGEU = 5'd15
    } alu_op_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } ctrl_state_e;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2
    } src1_sel_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JALR   = 2'd2
    } pc_sel_e;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I_ALU  = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8,
        CLS_FENCE  = 4'd9,
        CLS_NONE   = 4'd10
    } instr_class_e;

    // Register/immediate ALU op from funct3; alt selects sub/sra.
    function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic alu_op_e branch_op_from_f3(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b000:  op = ALU_BEQ;
            3'b001:  op = ALU_BNE;
            3'b100:  op = ALU_BLT;
            3'b101:  op = ALU_BGE;
            3'b110:  op = ALU_BLTU;
            3'b111:  op = ALU_BGEU;
            default: op = ALU_BEQ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32_instr_decoder.sv
// Combinational RV32I decoder: instruction word to class, ALU op,
// immediate format and an illegal-encoding flag.
module rv32_instr_decoder import rv32_pkg::*; (
    input  logic [31:0]  instr,
    output instr_class_e instr_class,
    output alu_op_e      alu_op,
    output imm_sel_e     imm_sel,
    output logic         illegal
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       unused_fields_s;

    assign opcode_s        = instr[6:0];
    assign funct3_s        = instr[14:12];
    assign funct7_s        = instr[31:25];
    assign unused_fields_s = ^{instr[24:15], instr[11:7]};

    // Opcode classification and per-class legality of funct3/funct7
    always_comb begin
        instr_class = CLS_NONE;
        alu_op      = ALU_ADD;
        imm_sel     = IMM_I;
        illegal     = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                instr_class = CLS_R;
                alu_op      = alu_op_from_f3(funct3_s, instr[30]);
                if (funct7_s == 7'h00) begin
                    illegal = 1'b0;
                end else if ((funct7_s == 7'h20) &&
                             ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
                    illegal = 1'b0;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                instr_class = CLS_I_ALU;
                if (funct3_s == 3'b000) begin
                    alu_op = ALU_ADD;
                end else begin
                    alu_op = alu_op_from_f3(funct3_s, instr[30]);
                end
                // Only the shift-immediates constrain funct7
                if (funct3_s == 3'b001) begin
                    illegal = (funct7_s != 7'h00);
                end else if (funct3_s == 3'b101) begin
                    illegal = !((funct7_s == 7'h00) || (funct7_s == 7'h20));
                end else begin
                    illegal = 1'b0;
                end
            end
            OPC_LOAD: begin
                instr_class = CLS_LOAD;
                illegal     = (funct3_s == 3'b011) || (funct3_s == 3'b110) ||
                              (funct3_s == 3'b111);
            end
            OPC_STORE: begin
                instr_class = CLS_STORE;
                imm_sel     = IMM_S;
                illegal     = (funct3_s > 3'b010);
            end
            OPC_BRANCH: begin
                instr_class = CLS_BRANCH;
                imm_sel     = IMM_B;
                alu_op      = branch_op_from_f3(funct3_s);
                illegal     = (funct3_s == 3'b010) || (funct3_s == 3'b011);
            end
            OPC_LUI: begin
                instr_class = CLS_LUI;
                imm_sel     = IMM_U;
            end
            OPC_AUIPC: begin
                instr_class = CLS_AUIPC;
                imm_sel     = IMM_U;
            end
            OPC_JAL: begin
                instr_class = CLS_JAL;
                imm_sel     = IMM_J;
            end
            OPC_JALR: begin
                instr_class = CLS_JALR;
            end
            OPC_MISC_MEM: begin
                instr_class = CLS_FENCE;
            end
            OPC_SYSTEM: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv32_multicycle_control.sv
// Main control FSM of the RV32I multicycle core: sequences
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the datapath selects.
module rv32_multicycle_control import rv32_pkg::*; (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instr_i,
    input  logic        mem_ready_i,
    input  logic        branch_feedback_i,
    output logic [4:0]  ALU_op_o,
    output logic [1:0]  alu_src1_sel_o,
    output logic        alu_src2_sel_o,
    output logic [2:0]  imm_sel_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_addr_sel_o,
    output logic [2:0]  mem_size_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic [1:0]  wb_sel_o,
    output logic        pc_write_o,
    output logic [1:0]  pc_sel_o,
    output logic        retire_o,
    output logic        illegal_o,
    output logic [2:0]  state_o
);

    ctrl_state_e  state_r;
    ctrl_state_e  state_n_s;
    instr_class_e instr_class_s;
    alu_op_e      dec_alu_op_s;
    imm_sel_e     dec_imm_sel_s;
    logic         dec_illegal_s;
    logic         rd_nonzero_s;

    logic [4:0]   alu_op_s;
    logic [1:0]   src1_sel_s;
    logic         src2_sel_s;
    logic [2:0]   imm_sel_s;
    logic         mem_req_s;
    logic         mem_we_s;
    logic         mem_addr_sel_s;
    logic [2:0]   mem_size_s;
    logic         ir_write_s;
    logic         reg_write_s;
    logic [1:0]   wb_sel_s;
    logic         pc_write_s;
    logic [1:0]   pc_sel_s;
    logic         retire_s;
    logic         illegal_s;

    assign rd_nonzero_s = |instr_i[11:7];

    rv32_instr_decoder u_decoder (
        .instr       (instr_i),
        .instr_class (instr_class_s),
        .alu_op      (dec_alu_op_s),
        .imm_sel     (dec_imm_sel_s),
        .illegal     (dec_illegal_s)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic; unreachable encodings fall into TRAP
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (mem_ready_i) begin
                    state_n_s = ST_DECODE;
                end else begin
                    state_n_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_illegal_s) begin
                    state_n_s = ST_TRAP;
                end else if (instr_class_s == CLS_JAL) begin
                    state_n_s = ST_WRITEBACK;
                end else if (instr_class_s == CLS_FENCE) begin
                    state_n_s = ST_FETCH;
                end else begin
                    state_n_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                case (instr_class_s)
                    CLS_LOAD, CLS_STORE:                            state_n_s = ST_MEM;
                    CLS_R, CLS_I_ALU, CLS_LUI, CLS_AUIPC, CLS_JALR: state_n_s = ST_WRITEBACK;
                    CLS_BRANCH:                                     state_n_s = ST_FETCH;
                    default:                                        state_n_s = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                if (!mem_ready_i) begin
                    state_n_s = ST_MEM;
                end else if (instr_class_s == CLS_LOAD) begin
                    state_n_s = ST_WRITEBACK;
                end else begin
                    state_n_s = ST_FETCH;
                end
            end
            ST_WRITEBACK: state_n_s = ST_FETCH;
            ST_TRAP:      state_n_s = ST_TRAP;
            default:      state_n_s = ST_TRAP;
        endcase
    end

    // Datapath controls decoded from the current state and instruction
    always_comb begin
        alu_op_s       = 5'd0;
        src1_sel_s     = 2'd0;
        src2_sel_s     = 1'b0;
        imm_sel_s      = 3'd0;
        mem_req_s      = 1'b0;
        mem_we_s       = 1'b0;
        mem_addr_sel_s = 1'b0;
        mem_size_s     = 3'd0;
        ir_write_s     = 1'b0;
        reg_write_s    = 1'b0;
        wb_sel_s       = 2'd0;
        pc_write_s     = 1'b0;
        pc_sel_s       = 2'd0;
        retire_s       = 1'b0;
        illegal_s      = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_req_s  = 1'b1;
                mem_size_s = 3'b010;
                ir_write_s = mem_ready_i;
            end
            ST_DECODE: begin
                imm_sel_s = dec_imm_sel_s;
                if (!dec_illegal_s && (instr_class_s == CLS_FENCE)) begin
                    pc_write_s = 1'b1;
                    pc_sel_s   = PC_PLUS4;
                    retire_s   = 1'b1;
                end else begin
                    pc_write_s = 1'b0;
                end
            end
            ST_EXECUTE: begin
                alu_op_s  = dec_alu_op_s;
                imm_sel_s = dec_imm_sel_s;
                case (instr_class_s)
                    CLS_LUI:   src1_sel_s = SRC1_ZERO;
                    CLS_AUIPC: src1_sel_s = SRC1_PC;
                    default:   src1_sel_s = SRC1_RS1;
                endcase
                src2_sel_s = !((instr_class_s == CLS_R) || (instr_class_s == CLS_BRANCH));
                if (instr_class_s == CLS_BRANCH) begin
                    pc_write_s = 1'b1;
                    pc_sel_s   = branch_feedback_i ? PC_BRANCH : PC_PLUS4;
                    retire_s   = 1'b1;
                end else begin
                    pc_write_s = 1'b0;
                end
            end
            ST_MEM: begin
                mem_req_s      = 1'b1;
                mem_addr_sel_s = 1'b1;
                mem_we_s       = (instr_class_s == CLS_STORE);
                mem_size_s     = instr_i[14:12];
                if (mem_ready_i && (instr_class_s == CLS_STORE)) begin
                    pc_write_s = 1'b1;
                    pc_sel_s   = PC_PLUS4;
                    retire_s   = 1'b1;
                end else begin
                    pc_write_s = 1'b0;
                end
            end
            ST_WRITEBACK: begin
                imm_sel_s   = dec_imm_sel_s;
                reg_write_s = rd_nonzero_s;
                pc_write_s  = 1'b1;
                retire_s    = 1'b1;
                case (instr_class_s)
                    CLS_LOAD: begin
                        wb_sel_s = WB_LOAD;
                        pc_sel_s = PC_PLUS4;
                    end
                    CLS_JAL: begin
                        wb_sel_s = WB_PC4;
                        pc_sel_s = PC_BRANCH;
                    end
                    CLS_JALR: begin
                        wb_sel_s = WB_PC4;
                        pc_sel_s = PC_JALR;
                    end
                    default: begin
                        wb_sel_s = WB_ALU;
                        pc_sel_s = PC_PLUS4;
                    end
                endcase
            end
            ST_TRAP: illegal_s = 1'b1;
            default: illegal_s = 1'b1;
        endcase
    end

    // The async reset flops only the state; outputs must also be quiet while it is held
    assign ALU_op_o       = rst_ni ? alu_op_s       : 5'd0;
    assign alu_src1_sel_o = rst_ni ? src1_sel_s     : 2'd0;
    assign alu_src2_sel_o = rst_ni ? src2_sel_s     : 1'b0;
    assign imm_sel_o      = rst_ni ? imm_sel_s      : 3'd0;
    assign mem_req_o      = rst_ni ? mem_req_s      : 1'b0;
    assign mem_we_o       = rst_ni ? mem_we_s       : 1'b0;
    assign mem_addr_sel_o = rst_ni ? mem_addr_sel_s : 1'b0;
    assign mem_size_o     = rst_ni ? mem_size_s     : 3'd0;
    assign ir_write_o     = rst_ni ? ir_write_s     : 1'b0;
    assign reg_write_o    = rst_ni ? reg_write_s    : 1'b0;
    assign wb_sel_o       = rst_ni ? wb_sel_s       : 2'd0;
    assign pc_write_o     = rst_ni ? pc_write_s     : 1'b0;
    assign pc_sel_o       = rst_ni ? pc_sel_s       : 2'd0;
    assign retire_o       = rst_ni ? retire_s       : 1'b0;
    assign illegal_o      = rst_ni ? illegal_s      : 1'b0;
    assign state_o        = rst_ni ? state_r        : 3'd0;

endmodule

// File: tb/tb_rv32_multicycle_control.sv
// Directed self-checking bench for rv32_multicycle_control.
module tb_rv32_multicycle_control;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] instr_i = 32'd0;
    logic        mem_ready_i = 1'b0;
    logic        branch_feedback_i = 1'b0;
    logic [4:0]  ALU_op_o;
    logic [1:0]  alu_src1_sel_o;
    logic        alu_src2_sel_o;
    logic [2:0]  imm_sel_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic        mem_addr_sel_o;
    logic [2:0]  mem_size_o;
    logic        ir_write_o;
    logic        reg_write_o;
    logic [1:0]  wb_sel_o;
    logic        pc_write_o;
    logic [1:0]  pc_sel_o;
    logic        retire_o;
    logic        illegal_o;
    logic [2:0]  state_o;

    int          n_checks = 0;
    int          n_fails = 0;
    int          retire_cnt = 0;
    logic [31:0] cur_instr = 32'd0;

    rv32_multicycle_control dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .instr_i           (instr_i),
        .mem_ready_i       (mem_ready_i),
        .branch_feedback_i (branch_feedback_i),
        .ALU_op_o          (ALU_op_o),
        .alu_src1_sel_o    (alu_src1_sel_o),
        .alu_src2_sel_o    (alu_src2_sel_o),
        .imm_sel_o         (imm_sel_o),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_addr_sel_o    (mem_addr_sel_o),
        .mem_size_o        (mem_size_o),
        .ir_write_o        (ir_write_o),
        .reg_write_o       (reg_write_o),
        .wb_sel_o          (wb_sel_o),
        .pc_write_o        (pc_write_o),
        .pc_sel_o          (pc_sel_o),
        .retire_o          (retire_o),
        .illegal_o         (illegal_o),
        .state_o           (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle: drive inputs on the falling edge, sample 1 time unit later
    task automatic cyc(input logic rdy, input logic fb);
        @(negedge clk_i);
        instr_i           = cur_instr;
        mem_ready_i       = rdy;
        branch_feedback_i = fb;
        #1;
        if (retire_o) retire_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni      = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        check_eq("rst_mem_req",  32'(mem_req_o),  32'd0);
        check_eq("rst_ir_write", 32'(ir_write_o), 32'd0);
        check_eq("rst_illegal",  32'(illegal_o),  32'd0);
        check_eq("rst_state",    32'(state_o),    32'd0);
        @(posedge clk_i);
        #2;
        rst_ni      = 1'b1;
        mem_ready_i = 1'b0;
    endtask

    task automatic trap_test(input string tag, input logic [31:0] ins);
        do_reset();
        cur_instr = ins;
        cyc(1'b1, 1'b0);
        check_eq({tag, "_f_state"}, 32'(state_o), 32'd0);
        cyc(1'b0, 1'b0);
        check_eq({tag, "_d_state"}, 32'(state_o), 32'd1);
        cyc(1'b0, 1'b0);
        check_eq({tag, "_t_state"},   32'(state_o),   32'd5);
        check_eq({tag, "_t_illegal"}, 32'(illegal_o), 32'd1);
        check_eq({tag, "_t_req"},     32'(mem_req_o), 32'd0);
        cyc(1'b1, 1'b0);
        check_eq({tag, "_t2_state"},   32'(state_o),    32'd5);
        check_eq({tag, "_t2_illegal"}, 32'(illegal_o),  32'd1);
        check_eq({tag, "_t2_req"},     32'(mem_req_o),  32'd0);
        check_eq({tag, "_t2_irw"},     32'(ir_write_o), 32'd0);
        check_eq({tag, "_t2_pcw"},     32'(pc_write_o), 32'd0);
    endtask

    initial begin
        do_reset();

        // add x3,x1,x2: F D E W
        cur_instr = 32'h002081B3;
        cyc(1'b1, 1'b0);
        check_eq("add_f_state", 32'(state_o),        32'd0);
        check_eq("add_f_req",   32'(mem_req_o),      32'd1);
        check_eq("add_f_addr",  32'(mem_addr_sel_o), 32'd0);
        check_eq("add_f_irw",   32'(ir_write_o),     32'd1);
        cyc(1'b0, 1'b0);
        check_eq("add_d_state", 32'(state_o),    32'd1);
        check_eq("add_d_irw",   32'(ir_write_o), 32'd0);
        check_eq("add_d_aluop", 32'(ALU_op_o),   32'd0);
        cyc(1'b0, 1'b0);
        check_eq("add_e_state", 32'(state_o),        32'd2);
        check_eq("add_e_aluop", 32'(ALU_op_o),       32'd0);
        check_eq("add_e_src2",  32'(alu_src2_sel_o), 32'd0);
        check_eq("add_e_ret",   32'(retire_o),       32'd0);
        cyc(1'b0, 1'b0);
        check_eq("add_w_state", 32'(state_o),     32'd4);
        check_eq("add_w_regw",  32'(reg_write_o), 32'd1);
        check_eq("add_w_wbsel", 32'(wb_sel_o),    32'd0);
        check_eq("add_w_ret",   32'(retire_o),    32'd1);
        check_eq("add_w_pcw",   32'(pc_write_o),  32'd1);
        check_eq("add_w_pcsel", 32'(pc_sel_o),    32'd0);

        // sub x3,x1,x2
        cur_instr = 32'h402081B3;
        cyc(1'b1, 1'b0);
        check_eq("sub_f_state", 32'(state_o), 32'd0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check_eq("sub_e_aluop", 32'(ALU_op_o), 32'd1);
        cyc(1'b0, 1'b0);
        check_eq("sub_w_ret", 32'(retire_o), 32'd1);

        // beq x1,x2,+8 taken then not taken: F D E
        cur_instr = 32'h00208463;
        cyc(1'b1, 1'b0);
        check_eq("beq1_f_state", 32'(state_o), 32'd0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        check_eq("beq1_e_state", 32'(state_o),        32'd2);
        check_eq("beq1_e_aluop", 32'(ALU_op_o),       32'd10);
        check_eq("beq1_e_pcw",   32'(pc_write_o),     32'd1);
        check_eq("beq1_e_pcsel", 32'(pc_sel_o),       32'd1);
        check_eq("beq1_e_ret",   32'(retire_o),       32'd1);
        check_eq("beq1_e_src2",  32'(alu_src2_sel_o), 32'd0);
        check_eq("beq1_e_imm",   32'(imm_sel_o),      32'd2);
        cyc(1'b1, 1'b0);
        check_eq("beq0_f_state", 32'(state_o), 32'd0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check_eq("beq0_e_pcw",   32'(pc_write_o), 32'd1);
        check_eq("beq0_e_pcsel", 32'(pc_sel_o),   32'd0);

        // lw x3,0(x1) with two wait cycles in FETCH and in MEM: 9 cycles
        cur_instr = 32'h0000A183;
        cyc(1'b0, 1'b0);
        check_eq("lw_f0_state", 32'(state_o),    32'd0);
        check_eq("lw_f0_req",   32'(mem_req_o),  32'd1);
        check_eq("lw_f0_irw",   32'(ir_write_o), 32'd0);
        cyc(1'b0, 1'b0);
        check_eq("lw_f1_req", 32'(mem_req_o), 32'd1);
        cyc(1'b1, 1'b0);
        check_eq("lw_f2_irw", 32'(ir_write_o), 32'd1);
        cyc(1'b0, 1'b0);
        check_eq("lw_d_state", 32'(state_o), 32'd1);
        cyc(1'b0, 1'b0);
        check_eq("lw_e_state", 32'(state_o),        32'd2);
        check_eq("lw_e_src2",  32'(alu_src2_sel_o), 32'd1);
        cyc(1'b0, 1'b0);
        check_eq("lw_m0_state", 32'(state_o),        32'd3);
        check_eq("lw_m0_req",   32'(mem_req_o),      32'd1);
        check_eq("lw_m0_addr",  32'(mem_addr_sel_o), 32'd1);
        check_eq("lw_m0_we",    32'(mem_we_o),       32'd0);
        check_eq("lw_m0_size",  32'(mem_size_o),     32'd2);
        check_eq("lw_m0_aluop", 32'(ALU_op_o),       32'd0);
        cyc(1'b0, 1'b0);
        check_eq("lw_m1_req",  32'(mem_req_o),  32'd1);
        check_eq("lw_m1_size", 32'(mem_size_o), 32'd2);
        cyc(1'b1, 1'b0);
        check_eq("lw_m2_state", 32'(state_o),  32'd3);
        check_eq("lw_m2_ret",   32'(retire_o), 32'd0);
        cyc(1'b0, 1'b0);
        check_eq("lw_w_state", 32'(state_o),     32'd4);
        check_eq("lw_w_wbsel", 32'(wb_sel_o),    32'd1);
        check_eq("lw_w_regw",  32'(reg_write_o), 32'd1);
        check_eq("lw_w_ret",   32'(retire_o),    32'd1);

        // lui x5,0x12345
        cur_instr = 32'h123452B7;
        cyc(1'b1, 1'b0);
        check_eq("lui_f_state", 32'(state_o), 32'd0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check_eq("lui_e_src1", 32'(alu_src1_sel_o), 32'd2);
        check_eq("lui_e_src2", 32'(alu_src2_sel_o), 32'd1);
        check_eq("lui_e_imm",  32'(imm_sel_o),      32'd3);
        cyc(1'b0, 1'b0);
        check_eq("lui_w_regw", 32'(reg_write_o), 32'd1);

        // jalr x0,0(x1): rd=0 suppresses the register write
        cur_instr = 32'h00008067;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check_eq("jalr_e_src1", 32'(alu_src1_sel_o), 32'd0);
        check_eq("jalr_e_src2", 32'(alu_src2_sel_o), 32'd1);
        cyc(1'b0, 1'b0);
        check_eq("jalr_w_state", 32'(state_o),     32'd4);
        check_eq("jalr_w_regw",  32'(reg_write_o), 32'd0);
        check_eq("jalr_w_wbsel", 32'(wb_sel_o),    32'd2);
        check_eq("jalr_w_pcsel", 32'(pc_sel_o),    32'd2);

        // jal x1,+8: F D W
        cur_instr = 32'h008000EF;
        cyc(1'b1, 1'b0);
        check_eq("jal_f_state", 32'(state_o), 32'd0);
        cyc(1'b0, 1'b0);
        check_eq("jal_d_state", 32'(state_o), 32'd1);
        cyc(1'b0, 1'b0);
        check_eq("jal_w_state", 32'(state_o),     32'd4);
        check_eq("jal_w_wbsel", 32'(wb_sel_o),    32'd2);
        check_eq("jal_w_pcsel", 32'(pc_sel_o),    32'd1);
        check_eq("jal_w_imm",   32'(imm_sel_o),   32'd4);
        check_eq("jal_w_regw",  32'(reg_write_o), 32'd1);

        // fence retires from DECODE
        cur_instr = 32'h0000000F;
        cyc(1'b1, 1'b0);
        check_eq("fence_f_state", 32'(state_o), 32'd0);
        cyc(1'b0, 1'b0);
        check_eq("fence_d_pcw",   32'(pc_write_o),  32'd1);
        check_eq("fence_d_pcsel", 32'(pc_sel_o),    32'd0);
        check_eq("fence_d_ret",   32'(retire_o),    32'd1);
        check_eq("fence_d_regw",  32'(reg_write_o), 32'd0);

        // sw x2,4(x1), reset dropped while the store waits in MEM
        cur_instr = 32'h0020A223;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check_eq("sw_e_imm",  32'(imm_sel_o),      32'd1);
        check_eq("sw_e_src2", 32'(alu_src2_sel_o), 32'd1);
        cyc(1'b0, 1'b0);
        check_eq("sw_m_state", 32'(state_o),        32'd3);
        check_eq("sw_m_req",   32'(mem_req_o),      32'd1);
        check_eq("sw_m_we",    32'(mem_we_o),       32'd1);
        check_eq("sw_m_addr",  32'(mem_addr_sel_o), 32'd1);
        check_eq("sw_m_size",  32'(mem_size_o),     32'd2);
        #1;
        rst_ni = 1'b0;
        #1;
        check_eq("sw_rst_req",   32'(mem_req_o),  32'd0);
        check_eq("sw_rst_we",    32'(mem_we_o),   32'd0);
        check_eq("sw_rst_state", 32'(state_o),    32'd0);
        check_eq("sw_rst_ret",   32'(retire_o),   32'd0);
        check_eq("sw_rst_pcw",   32'(pc_write_o), 32'd0);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        cyc(1'b0, 1'b0);
        check_eq("sw_post_state", 32'(state_o),   32'd0);
        check_eq("sw_post_ret",   32'(retire_o),  32'd0);
        check_eq("sw_post_req",   32'(mem_req_o), 32'd1);

        trap_test("allones", 32'hFFFFFFFF);
        trap_test("ecall",   32'h00000073);
        trap_test("badf7",   32'h022081B3);

        check_eq("retire_total", 32'(retire_cnt), 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
